ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
// - Streams a configuration bitstream into the ccff shift chain of a routing tile (switch block / connection block).
// - Takes WORD_W-bit words over a valid/ready port and serialises them MSB-first onto ccff_head.
// - Gates chain clocking with chain_clk_en, so the chain advances exactly CHAIN_LEN times per load.
// - Sits between the bitstream fetch logic and the tile's ccff_head/ccff_tail pins.
// PARAMETERS
// - CHAIN_LEN  48  total config bits in the chain (e.g. 12 mux mems x 4 bits); must be >= 1.
// - WORD_W     32  input word width; words per load = ceil(CHAIN_LEN/WORD_W).
// PORTS
// - prog_clk       in   1       programming clock; the only clock.
// - prog_rst_n     in   1       asynchronous, active-low reset.
// - start          in   1       1-cycle request to begin a load; honoured only in IDLE.
// - abort          in   1       terminates a load in progress; no effect in IDLE.
// - s_valid        in   1       input word valid.
// - s_ready        out  1       input word accepted when s_valid & s_ready.
// - s_data         in   WORD_W  configuration word, bit WORD_W-1 shifted first.
// - ccff_head      out  1       serial data to the chain head (registered).
// - chain_clk_en   out  1       clock-gate enable for the chain's prog_clk (registered).
// - ccff_tail      in   1       serial data returning from the chain tail.
// - busy           out  1       high from the cycle after an accepted start until DONE exits.
// - done           out  1       1-cycle pulse: all CHAIN_LEN bits shifted.
// - aborted        out  1       1-cycle pulse: load terminated by abort.
// BEHAVIOUR
// - Reset values: s_ready=0, ccff_head=0, chain_clk_en=0, busy=0, done=0, aborted=0. FSM=IDLE, counters=0.
// - FSM states: IDLE, FETCH, SHIFT, DONE.
//   - IDLE -> FETCH on start.
//   - FETCH: s_ready=1. On handshake, latch the word -> SHIFT.
//   - SHIFT: one bit per cycle.
//     - After the last bit of a word with bits remaining: -> FETCH, or stay in SHIFT if a prefetch handshake occurred.
//     - After bit CHAIN_LEN-1: -> DONE.
//   - DONE: done=1 for one cycle -> IDLE.
// - Bit k of the load (k=0..CHAIN_LEN-1) is driven on ccff_head with chain_clk_en=1 for exactly one cycle.
//   chain_clk_en is 0 in every other cycle. The chain captures at the rising prog_clk edge ending that cycle.
// - Latency:
//   - start accepted at cycle T -> s_ready=1 at T+1.
//   - Word handshake at cycle H -> its first bit is on ccff_head with chain_clk_en=1 at H+1.
// - Prefetch: s_ready=1 during the SHIFT cycle of a word's last bit when more bits remain.
//   If s_valid=1 then, there is no enable bubble between words.
// - Stalls: in FETCH with s_valid=0, chain_clk_en=0 and ccff_head holds its value. No bits are lost or duplicated.
// - Last word: only the top (CHAIN_LEN - (words-1)*WORD_W) bits are used; lower bits are ignored.
//   Example: 48/32 uses s_data[31:16] of word 2.
// - Counters:
//   - bit-in-word counter wraps at WORD_W-1 (or at the partial length for the last word).
//   - total counter is clog2(CHAIN_LEN+1) bits and saturates at CHAIN_LEN.
// - start is ignored while busy.
// - abort in any non-IDLE state:
//   - next cycle: state=IDLE, chain_clk_en=0, s_ready=0, aborted=1 for one cycle, done not asserted.
//   - the chain is left partially shifted.
// - abort and start in the same cycle in IDLE: start wins.
// - abort in DONE: done still pulses; aborted stays 0.
// - Reset asserted mid-load: all outputs go to reset values immediately (asynchronous); the partial load is discarded.
// CONFIGURATION
// - CCFF_READBACK_EN defined:
//   - adds output rb_ones [clog2(CHAIN_LEN+1)-1:0] = count of ccff_tail==1 sampled in each enabled cycle of the last load.
//   - this is the population count of the previous chain contents.
//   - cleared on start accept; holds after done or abort; 0 at reset.
// - CCFF_READBACK_EN undefined: no rb_ones port; ccff_tail is unused.
// TESTING
// - Words 0xA5A5F00F, 0x1234FFFF, s_valid always 1:
//   ccff_head = 1010_0101_1010_0101_1111_0000_0000_1111_0001_0010_0011_0100.
//   chain_clk_en high for 48 consecutive cycles; done at cycle 49 after the first handshake.
// - s_valid low 3 cycles before word 2: chain_clk_en low for exactly those 3 cycles; still 48 enabled cycles total.
// - abort at enabled bit 20: chain_clk_en=0 next cycle, aborted=1 for 1 cycle, done never asserted, busy=0.
// - start re-pulsed at bit 10 of a load: ignored; bit count and data sequence unchanged.
// - prog_rst_n low at bit 30: all outputs 0 immediately; after release a fresh load completes normally.
// - With CCFF_READBACK_EN: load all-ones, then load all-zeros -> rb_ones=48 after the second done.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Streams WORD_W-bit configuration words MSB-first into a tile's ccff chain,
// gating the chain clock so it advances exactly CHAIN_LEN times per load.
// Optional build macro CCFF_READBACK_EN adds rb_ones, a popcount of ccff_tail over the last load.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef CCFF_READBACK_EN
  ,
  output logic [$clog2(CHAIN_LEN+1)-1:0] rb_ones
`endif
);

  localparam int TW = $clog2(CHAIN_LEN + 1);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [TW-1:0]     tot_q, tot_d;
  logic              head_d, en_d, abt_d;
  logic              last_bit, word_end, hs, start_acc;

  // tot_q is the load index of the bit currently on ccff_head while in SHIFT
  assign last_bit  = (tot_q == TW'(CHAIN_LEN - 1));
  assign word_end  = (bit_q == BW'(WORD_W - 1)) || last_bit;
  // abort masks ready so a word is never consumed by a load that is being dropped
  assign s_ready   = !abort && ((state_q == FETCH) ||
                                (state_q == SHIFT && word_end && !last_bit));
  assign hs        = s_valid && s_ready;
  assign start_acc = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    tot_d   = tot_q;
    head_d  = ccff_head;
    en_d    = 1'b0;
    abt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          tot_d   = '0;
          bit_d   = '0;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
          abt_d   = 1'b1;
        end else if (hs) begin
          head_d  = s_data[WORD_W-1];
          word_d  = s_data << 1;
          bit_d   = '0;
          en_d    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tot_q != TW'(CHAIN_LEN)) tot_d = tot_q + TW'(1);
        if (abort) begin
          state_d = IDLE;
          abt_d   = 1'b1;
        end else if (last_bit) begin
          state_d = DONE;
        end else if (word_end) begin
          bit_d = '0;
          if (hs) begin
            // prefetched word: first bit follows with no enable bubble
            head_d = s_data[WORD_W-1];
            word_d = s_data << 1;
            en_d   = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end else begin
          head_d = word_q[WORD_W-1];
          word_d = word_q << 1;
          bit_d  = bit_q + BW'(1);
          en_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      bit_q        <= '0;
      tot_q        <= '0;
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      bit_q        <= bit_d;
      tot_q        <= tot_d;
      ccff_head    <= head_d;
      chain_clk_en <= en_d;
      aborted      <= abt_d;
    end
  end

`ifdef CCFF_READBACK_EN
  // every enabled cycle pops one old bit out of the tail
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n)                   rb_ones <= '0;
    else if (start_acc)                rb_ones <= '0;
    else if (chain_clk_en && ccff_tail) rb_ones <= rb_ones + TW'(1);
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail ^ start_acc;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader (48-bit chain, 32-bit words) with a behavioural chain model.
module tb_ccff_chain_loader;

  logic        prog_clk = 1'b0;
  logic        prog_rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, ccff_head, chain_clk_en, ccff_tail, busy, done, aborted;
  logic [47:0] chain = '0;
`ifdef CCFF_READBACK_EN
  logic [5:0]  rb_ones;
`endif

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(48), .WORD_W(32)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ccff_head(ccff_head), .chain_clk_en(chain_clk_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .aborted(aborted)
`ifdef CCFF_READBACK_EN
    , .rb_ones(rb_ones)
`endif
  );

  // chain model: gated shift register, head enters at bit 0, tail is bit 47
  always @(posedge prog_clk) if (chain_clk_en) chain <= {chain[46:0], ccff_head};
  assign ccff_tail = chain[47];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // results of the last do_load
  logic [47:0] seq;
  int en_cnt, hs, first_en, last_en, done_c, ab_c, n_done, n_ab, gaps;
  logic ab_en, ab_busy, busy_c1, end_busy;

  task automatic do_load(input logic [31:0] w0, input logic [31:0] w1, input int stall,
                         input int abort_bit, input int restart_bit, input int rst_bit,
                         input bit ab_start, input bit ab_done);
    int widx, stall_left, end_c;
    bit restarted, finished;
    seq = '0; en_cnt = 0; hs = -1; first_en = -1; last_en = -1; done_c = -1; ab_c = -1;
    n_done = 0; n_ab = 0; gaps = 0; ab_en = 1'bx; ab_busy = 1'bx; busy_c1 = 1'bx; end_busy = 1'bx;
    widx = 0; stall_left = stall; restarted = 0; end_c = -1; finished = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge prog_clk);
      start = (c == 0) || (restart_bit >= 0 && en_cnt == restart_bit && !restarted);
      if (start && c != 0) restarted = 1;
      abort = (c == 0 && ab_start) || (abort_bit >= 0 && en_cnt == abort_bit && ab_c < 0)
              || (ab_done && hs >= 0 && c == hs + 49);
      if (rst_bit >= 0 && en_cnt == rst_bit) prog_rst_n = 1'b0;
      s_valid = (widx == 0) ? (c >= 1) : (widx == 1) ? (stall_left == 0) : 1'b0;
      s_data  = (widx == 0) ? w0 : w1;
      #1;
      if (!prog_rst_n) begin
        chk("rst_mid_outputs", {58'd0, s_ready, ccff_head, chain_clk_en, busy, done, aborted}, 64'd0);
        start = 0; abort = 0; s_valid = 0;
        return;
      end
      if (c == 1) busy_c1 = busy;
      if (chain_clk_en) begin
        if (en_cnt < 48) seq[47-en_cnt] = ccff_head;
        if (first_en < 0) first_en = c;
        last_en = c;
        en_cnt++;
      end else if (first_en >= 0 && end_c < 0 && !done && !aborted) gaps++;
      if (s_ready && s_valid) begin
        if (widx == 0) hs = c;
        widx++;
      end else if (widx == 1 && s_ready && stall_left > 0) stall_left--;
      if (done)    begin n_done++; if (done_c < 0) done_c = c; end
      if (aborted) begin n_ab++;   if (ab_c < 0) begin ab_c = c; ab_en = chain_clk_en; ab_busy = busy; end end
      if ((done || aborted) && end_c < 0) end_c = c;
      if (end_c >= 0 && c == end_c + 2) begin end_busy = busy; finished = 1; break; end
    end
    start = 0; abort = 0; s_valid = 0;
    if (!finished) chk("load_timeout", 64'd0, 64'd1);
  endtask

  localparam logic [47:0] EXP_A = 48'hA5A5_F00F_1234;
  localparam logic [47:0] EXP_B = 48'h0000_FFFF_FFFF;

  initial begin
    repeat (3) @(negedge prog_clk);
    chk("reset_outputs", {58'd0, s_ready, ccff_head, chain_clk_en, busy, done, aborted}, 64'd0);
    prog_rst_n = 1'b1;
    @(negedge prog_clk);

    // basic load, s_valid always high
    do_load(32'hA5A5F00F, 32'h1234FFFF, 0, -1, -1, -1, 0, 0);
    chk("t1_hs_at_T+1", hs, 1);
    chk("t1_busy_after_start", busy_c1, 1);
    chk("t1_seq", seq, EXP_A);
    chk("t1_en_cnt", en_cnt, 48);
    chk("t1_first_en", first_en - hs, 1);
    chk("t1_last_en", last_en - hs, 48);
    chk("t1_gaps", gaps, 0);
    chk("t1_done_cyc", done_c - hs, 49);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_no_abort", n_ab, 0);
    chk("t1_idle_after", end_busy, 0);
    chk("t1_chain", chain, EXP_A);

    // three-cycle stall before word 2
    do_load(32'hA5A5F00F, 32'h1234FFFF, 3, -1, -1, -1, 0, 0);
    chk("t2_seq", seq, EXP_A);
    chk("t2_en_cnt", en_cnt, 48);
    chk("t2_gaps", gaps, 3);
    chk("t2_done_cyc", done_c - hs, 52);

    // abort on bit 20
    do_load(32'hA5A5F00F, 32'h1234FFFF, 0, 20, -1, -1, 0, 0);
    chk("t3_bits_shifted", en_cnt, 21);
    chk("t3_seq_prefix", seq >> 27, EXP_A >> 27);
    chk("t3_aborted_pulses", n_ab, 1);
    chk("t3_no_done", n_done, 0);
    chk("t3_en_after_abort", ab_en, 0);
    chk("t3_busy_after_abort", ab_busy, 0);

    // start re-pulsed during bit 10
    do_load(32'h0000FFFF, 32'hFFFF0000, 0, -1, 10, -1, 0, 0);
    chk("t4_seq", seq, EXP_B);
    chk("t4_en_cnt", en_cnt, 48);
    chk("t4_done_cyc", done_c - hs, 49);

    // reset at bit 30, then a fresh load
    do_load(32'hA5A5F00F, 32'h1234FFFF, 0, -1, -1, 30, 0, 0);
    repeat (2) @(negedge prog_clk);
    prog_rst_n = 1'b1;
    @(negedge prog_clk);
    do_load(32'h0000FFFF, 32'hFFFF0000, 0, -1, -1, -1, 0, 0);
    chk("t5_seq", seq, EXP_B);
    chk("t5_done_cyc", done_c - hs, 49);
    chk("t5_chain", chain, EXP_B);

    // abort together with start in IDLE: start wins
    do_load(32'hA5A5F00F, 32'h1234FFFF, 0, -1, -1, -1, 1, 0);
    chk("t6_hs", hs, 1);
    chk("t6_no_aborted", n_ab, 0);
    chk("t6_done", n_done, 1);

    // abort during DONE: done still pulses, no aborted
    do_load(32'hA5A5F00F, 32'h1234FFFF, 0, -1, -1, -1, 0, 1);
    chk("t7_done", n_done, 1);
    chk("t7_no_aborted", n_ab, 0);

`ifdef CCFF_READBACK_EN
    do_load(32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1, -1, -1, 0, 0);
    do_load(32'h00000000, 32'h00000000, 0, -1, -1, -1, 0, 0);
    chk("rb_ones_after_zero_load", rb_ones, 48);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
